// File: rtl/rename_free_list_pkg.sv
// Shared types and sizing for the rename-stage physical register free list.
package rename_free_list_pkg;

    localparam int TABLE_ENTRIES = 64;
    localparam int ARCH_REGS     = 32;
    localparam int FREE_DEPTH    = TABLE_ENTRIES - ARCH_REGS;
    localparam int PREG_W        = $clog2(TABLE_ENTRIES);
    localparam int IDX_W         = $clog2(FREE_DEPTH);
    // One extra wrap bit distinguishes full from empty when indices match.
    localparam int PTR_W         = IDX_W + 1;

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [PTR_W-1:0]  ptr_t;

    // FREE_LIST names the speculative head, BACKUP_FREE_LIST the retirement head.
    typedef enum logic [0:0] {
        FREE_LIST        = 1'b0,
        BACKUP_FREE_LIST = 1'b1
    } initialization_t;

    // Storage index of a wrap-bit pointer.
    function automatic logic [IDX_W-1:0] ptr_idx(input ptr_t p);
        return p[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/rename_free_list_chk.sv
// Protocol checker for the free list commit interface.
module rename_free_list_chk
    import rename_free_list_pkg::*;
(
    input logic              clk,
    input logic              rst,
    input logic              commit_valid,
    input logic [PREG_W-1:0] commit_old_preg,
    input logic [PTR_W:0]    free_count
);

    // A commit can only return a tag when something is in flight.
    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(commit_valid && (free_count == (PTR_W+1)'(FREE_DEPTH))))
        else $error("commit pushed into a full free list");

    // p0 is permanently mapped to x0 and is never displaced.
    a_no_push_p0: assert property (@(posedge clk) disable iff (rst)
        !(commit_valid && (commit_old_preg == {PREG_W{1'b0}})))
        else $error("commit pushed physical register 0");

endmodule

// File: rtl/rename_free_list.sv
// Circular free list of physical register tags with a speculative head
// (rename) and a retirement head (commit) for single-cycle flush recovery.
module rename_free_list
    import rename_free_list_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rename_req,
    output logic              rename_ready,
    output logic [PREG_W-1:0] rename_preg,
    input  logic              commit_valid,
    input  logic [PREG_W-1:0] commit_old_preg,
    input  logic              flush,
    output logic [PTR_W:0]    free_count
);

    preg_t r_list [FREE_DEPTH];
    ptr_t  r_spec_head;
    ptr_t  r_retire_head;
    ptr_t  r_tail;

    ptr_t  w_count;
    logic  w_pop;
    logic  w_push;
    ptr_t  w_spec_head_nxt;
    ptr_t  w_retire_head_nxt;
    ptr_t  w_tail_nxt;

    assign w_count      = r_tail - r_spec_head;
    assign rename_ready = (w_count != {PTR_W{1'b0}});
    assign free_count   = {1'b0, w_count};
    // Zero-latency pop: no bypass from a same-cycle push.
    assign rename_preg  = r_list[ptr_idx(r_spec_head)];

    // Handshakes; a push into a completely free list is dropped.
    always_comb begin
        w_pop  = rename_req && rename_ready && !flush;
        w_push = commit_valid && (w_count != PTR_W'(FREE_DEPTH));
    end

    // Next pointer values; flush rewinds the speculative head to the
    // (possibly just-advanced) retirement head and cancels any pop.
    always_comb begin
        w_retire_head_nxt = r_retire_head;
        w_tail_nxt        = r_tail;
        w_spec_head_nxt   = r_spec_head;
        if (w_push) begin
            w_retire_head_nxt = r_retire_head + PTR_W'(1);
            w_tail_nxt        = r_tail + PTR_W'(1);
        end else begin
            w_retire_head_nxt = r_retire_head;
            w_tail_nxt        = r_tail;
        end
        if (flush) begin
            w_spec_head_nxt = w_retire_head_nxt;
        end else if (w_pop) begin
            w_spec_head_nxt = r_spec_head + PTR_W'(1);
        end else begin
            w_spec_head_nxt = r_spec_head;
        end
    end

    // Pointer registers; reset leaves the list full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_spec_head   <= {PTR_W{1'b0}};
            r_retire_head <= {PTR_W{1'b0}};
            r_tail        <= PTR_W'(FREE_DEPTH);
        end else begin
            r_spec_head   <= w_spec_head_nxt;
            r_retire_head <= w_retire_head_nxt;
            r_tail        <= w_tail_nxt;
        end
    end

    // Tag storage; reset loads the tags above the architectural mapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FREE_DEPTH; i++) begin
                r_list[i] <= preg_t'(ARCH_REGS + i);
            end
        end else if (w_push) begin
            r_list[ptr_idx(r_tail)] <= commit_old_preg;
        end else begin
            r_list[ptr_idx(r_tail)] <= r_list[ptr_idx(r_tail)];
        end
    end

endmodule
